memory_stage: RTL
=================

// Module: memory_stage
// PURPOSE
//  Pipeline stage directly downstream of execute. Latches the execute result, store data, opcode and rd.
//  Performs lw/sw through a variable-latency req/ack data-memory port and stalls upstream while waiting.
//  Presents a writeback record (rd, data, write-enable) to the writeback stage.
// PARAMETERS
//  ADDR_W       12  data-memory word-address width; dmem_addr = m_result[ADDR_W-1:0]
//  TIMEOUT_CYC  15  max cycles in ACCESS without dmem_ack before abort (>=1)
// PORTS
//  clk            in   1       single clock, all state on rising edge
//  clr            in   1       synchronous active-high reset
//  enable         in   1       pipeline advance from hazard control
//  ex_valid       in   1       execute holds a valid instruction
//  ex_opcode      in   5       opcode from execute
//  ex_rd          in   5       destination from execute (already 30 on overflow)
//  ex_result      in   32      execute_output (ALU result / address)
//  ex_store_data  in   32      data_out_regB (sw data)
//  dmem_req       out  1       memory request, held until ack
//  dmem_we        out  1       1 = store, 0 = load
//  dmem_addr      out  ADDR_W  word address
//  dmem_wdata     out  32      store data
//  dmem_ack       in   1       memory done; dmem_rdata valid same cycle
//  dmem_rdata     in   32      load data
//  stall          out  1       freeze execute and earlier stages
//  mem_valid      out  1       writeback record valid
//  mem_rd         out  5       writeback destination
//  mem_data       out  32      writeback data
//  mem_we_reg     out  1       register-file write enable
//  mem_timeout    out  1       sticky, set on memory abort
//  byp_valid      out  1       bypass to execute valid (see CONFIGURATION)
//  byp_rd         out  5       bypass destination
//  byp_data       out  32      bypass data
// BEHAVIOUR
//  - Reset (clr): m_valid=0, state=IDLE, wait_cnt=0, load_reg=0, mem_timeout=0.
//    All outputs are 0 the next cycle; dmem_req drops at that edge. A late dmem_ack in IDLE is ignored.
//  - Capture: if !stall && enable, the M regs load ex_* with m_valid=ex_valid.
//    If !stall && !enable, the M regs hold (a repeated writeback is idempotent).
//  - Decode of m_opcode: lw=01000, sw=00111, jal=00011 (rd forced 31), setx=10101 (rd forced 30).
//    ALU=00000, addi=00101. bne=00010, blt=00110, j=00001, jr=00100, bex=10110 do not write.
//  - FSM {IDLE, ACCESS}:
//    IDLE->ACCESS on the capture edge of a valid lw/sw; wait_cnt cleared.
//    ACCESS: dmem_req=1, dmem_we=is_sw, stall=1, wait_cnt++ each cycle without ack.
//    ACCESS->IDLE on dmem_ack: lw loads load_reg<=dmem_rdata.
//    ACCESS->IDLE on wait_cnt==TIMEOUT_CYC-1 without ack: mem_timeout<=1, load_reg<=0, write suppressed.
//    Ack in the same cycle as the timeout limit: ack wins, no timeout.
//  - stall = (state==ACCESS); it is combinational from state only, with no dependence on dmem_ack.
//  - Latency: non-memory op, mem_valid the cycle after capture.
//    Memory op with ack in ACCESS cycle k (k>=0), mem_valid at cycle k+1 after entering ACCESS.
//  - mem_valid = m_valid && state==IDLE. mem_data = is_lw ? load_reg : m_result. mem_rd = forced/m_rd.
//  - mem_we_reg = mem_valid && writes_reg && mem_rd!=0 && !aborted_this_op.
//  - Upper address bits above ADDR_W are truncated without error.
// CONFIGURATION
//  MEM_BYPASS_OUT_EN defined:
//    byp_valid=mem_we_reg, byp_rd=mem_rd, byp_data=mem_data, driving execute isBypassData_*/bypassData_*.
//    byp_valid is never 1 during ACCESS.
//  Not defined: byp_valid, byp_rd and byp_data are tied to 0 and the ports remain present.
// TESTING
//  - clr=1 2 cycles, then ADD rd=3 result=0x15 -> next cycle mem_valid=1, mem_rd=3, mem_data=0x15, mem_we_reg=1, stall=0.
//  - sw addr=0x010 data=0xDEAD, ack after 3 cycles -> req=1/we=1/addr=0x010 for 4 cycles, stall=1 same 4, mem_we_reg=0.
//  - lw rd=5 addr=0x020, rdata=0x1234 with ack in first ACCESS cycle -> stall 1 cycle, then mem_data=0x1234, mem_we_reg=1.
//  - lw with no ack, TIMEOUT_CYC=15 -> stall 15 cycles, then mem_timeout=1 (sticky), mem_we_reg=0; ack at cycle 15 instead -> no timeout.
//  - clr during ACCESS (cycle 2), ack at cycle 4 -> dmem_req=0 after clr, ack ignored, mem_valid stays 0.
//  - ADD rd=0 -> mem_we_reg=0. jal -> mem_rd=31.
//    With MEM_BYPASS_OUT_EN: byp_valid mirrors mem_we_reg; without it byp_* stay 0.

Source files
------------

// File: rtl/memory_stage.sv
// Memory pipeline stage: latches execute results, runs lw/sw over a req/ack port and
// presents the writeback record. Optional bypass outputs enabled by MEM_BYPASS_OUT_EN.
module memory_stage #(
    parameter int ADDR_W      = 12,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              enable,
    input  logic              ex_valid,
    input  logic [4:0]        ex_opcode,
    input  logic [4:0]        ex_rd,
    input  logic [31:0]       ex_result,
    input  logic [31:0]       ex_store_data,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [31:0]       dmem_wdata,
    input  logic              dmem_ack,
    input  logic [31:0]       dmem_rdata,
    output logic              stall,
    output logic              mem_valid,
    output logic [4:0]        mem_rd,
    output logic [31:0]       mem_data,
    output logic              mem_we_reg,
    output logic              mem_timeout,
    output logic              byp_valid,
    output logic [4:0]        byp_rd,
    output logic [31:0]       byp_data
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [4:0] OP_ALU  = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_LW   = 5'b01000;
    localparam logic [4:0] OP_SW   = 5'b00111;
    localparam logic [4:0] OP_JAL  = 5'b00011;
    localparam logic [4:0] OP_SETX = 5'b10101;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t             state_q, state_d;
    logic               m_valid_q, m_valid_d;
    logic [4:0]         m_opcode_q, m_opcode_d;
    logic [4:0]         m_rd_q, m_rd_d;
    logic [31:0]        m_result_q, m_result_d;
    logic [31:0]        m_store_q, m_store_d;
    logic [31:0]        load_reg_q, load_reg_d;
    logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic               timeout_q, timeout_d;
    logic               aborted_q, aborted_d;

    logic is_lw, is_sw, is_jal, is_setx, writes_reg, ex_is_mem, capture;

    assign is_lw      = (m_opcode_q == OP_LW);
    assign is_sw      = (m_opcode_q == OP_SW);
    assign is_jal     = (m_opcode_q == OP_JAL);
    assign is_setx    = (m_opcode_q == OP_SETX);
    assign writes_reg = (m_opcode_q == OP_ALU) || (m_opcode_q == OP_ADDI) || is_lw
                        || is_jal || is_setx;
    assign ex_is_mem  = (ex_opcode == OP_LW) || (ex_opcode == OP_SW);

    // Stall depends on state only so the hazard path never sees dmem_ack.
    assign stall   = (state_q == ACCESS);
    assign capture = !stall && enable;

    always_comb begin
        state_d    = state_q;
        m_valid_d  = m_valid_q;
        m_opcode_d = m_opcode_q;
        m_rd_d     = m_rd_q;
        m_result_d = m_result_q;
        m_store_d  = m_store_q;
        load_reg_d = load_reg_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        aborted_d  = aborted_q;

        if (capture) begin
            m_valid_d  = ex_valid;
            m_opcode_d = ex_opcode;
            m_rd_d     = ex_rd;
            m_result_d = ex_result;
            m_store_d  = ex_store_data;
            wait_cnt_d = '0;
            aborted_d  = 1'b0;
            if (ex_valid && ex_is_mem) begin
                state_d = ACCESS;
            end
        end

        if (state_q == ACCESS) begin
            // An ack on the limit cycle still completes the access.
            if (dmem_ack) begin
                state_d = IDLE;
                if (is_lw) begin
                    load_reg_d = dmem_rdata;
                end
            end else if (wait_cnt_q == CNT_LIM) begin
                state_d    = IDLE;
                timeout_d  = 1'b1;
                load_reg_d = '0;
                aborted_d  = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= IDLE;
            m_valid_q  <= 1'b0;
            m_opcode_q <= '0;
            m_rd_q     <= '0;
            m_result_q <= '0;
            m_store_q  <= '0;
            load_reg_q <= '0;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_valid_q  <= m_valid_d;
            m_opcode_q <= m_opcode_d;
            m_rd_q     <= m_rd_d;
            m_result_q <= m_result_d;
            m_store_q  <= m_store_d;
            load_reg_q <= load_reg_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
            aborted_q  <= aborted_d;
        end
    end

    assign dmem_req   = (state_q == ACCESS);
    assign dmem_we    = (state_q == ACCESS) && is_sw;
    assign dmem_addr  = m_result_q[ADDR_W-1:0];
    assign dmem_wdata = m_store_q;

    assign mem_valid   = m_valid_q && (state_q == IDLE);
    assign mem_rd      = is_jal ? 5'd31 : (is_setx ? 5'd30 : m_rd_q);
    assign mem_data    = is_lw ? load_reg_q : m_result_q;
    assign mem_we_reg  = mem_valid && writes_reg && (mem_rd != 5'd0) && !aborted_q;
    assign mem_timeout = timeout_q;

`ifdef MEM_BYPASS_OUT_EN
    assign byp_valid = mem_we_reg;
    assign byp_rd    = mem_rd;
    assign byp_data  = mem_data;
`else
    assign byp_valid = 1'b0;
    assign byp_rd    = 5'd0;
    assign byp_data  = 32'd0;
`endif

endmodule
